// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: per-channel edge mode encodings.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

endpackage

// File: rtl/input_conditioner_if.sv
// Channel bus of the input conditioner: raw inputs and controls in, conditioned outputs back.
interface input_conditioner_if #(
  parameter int unsigned CH = 4
);

  logic [CH-1:0]   async_in;
  logic [2*CH-1:0] edge_sel;
  logic [CH-1:0]   event_clr;
  logic [CH-1:0]   level_out;
  logic [CH-1:0]   rise_out;
  logic [CH-1:0]   fall_out;
  logic [CH-1:0]   edge_pulse;
  logic [CH-1:0]   event_flag;

  // Side that drives the pins and consumes the conditioned results.
  modport master (
    output async_in, edge_sel, event_clr,
    input  level_out, rise_out, fall_out, edge_pulse, event_flag
  );

  // Conditioner side.
  modport slave (
    input  async_in, edge_sel, event_clr,
    output level_out, rise_out, fall_out, edge_pulse, event_flag
  );

endinterface

// File: rtl/input_conditioner_ch.sv
// One conditioner channel: synchroniser, debounce counter, edge pulses and sticky event flag.
module input_conditioner_ch
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       async_in,
  input  logic [1:0] edge_sel,
  input  logic       event_clr,
  output logic       level_out,
  output logic       rise_out,
  output logic       fall_out,
  output logic       edge_pulse,
  output logic       event_flag
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   q;
  logic                   s;
  logic                   accept;
  logic                   pulse_set;
  logic                   rise_en;
  logic                   fall_en;
  edge_mode_e             mode;

  // Decode the synchronised level, acceptance and the mode-filtered edge condition.
  always_comb begin
    s         = sync[SYNC_STAGES-1];
    mode      = edge_mode_e'(edge_sel);
    rise_en   = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    fall_en   = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    accept    = (s != q) && (cnt == CW'(DB_CYCLES - 1));
    pulse_set = accept && ((s && rise_en) || (!s && fall_en));
  end

  // Synchronise, debounce and register the level, pulses and sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= {SYNC_STAGES{RESET_LEVEL}};
      q          <= RESET_LEVEL;
      cnt        <= '0;
      rise_out   <= 1'b0;
      fall_out   <= 1'b0;
      edge_pulse <= 1'b0;
      event_flag <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], async_in};
      rise_out   <= accept && s;
      fall_out   <= accept && !s;
      edge_pulse <= pulse_set;
      // set has priority over a simultaneous clear
      event_flag <= pulse_set || (event_flag && !event_clr);
      if (s == q) begin
        cnt <= '0;
      end else if (accept) begin
        q   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level_out = q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner top: replicates one channel per input bit and slices the bus.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 16,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  input_conditioner_if.slave bus
);

  logic [CH-1:0] level;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] pulse;
  logic [CH-1:0] flag;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    input_conditioner_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .async_in   (bus.async_in[i]),
      .edge_sel   (bus.edge_sel[2*i+1:2*i]),
      .event_clr  (bus.event_clr[i]),
      .level_out  (level[i]),
      .rise_out   (rise[i]),
      .fall_out   (fall[i]),
      .edge_pulse (pulse[i]),
      .event_flag (flag[i])
    );
  end

  assign bus.level_out  = level;
  assign bus.rise_out   = rise;
  assign bus.fall_out   = fall;
  assign bus.edge_pulse = pulse;
  assign bus.event_flag = flag;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench: default conditioner plus a fast (SYNC_STAGES=3, DB_CYCLES=1) instance.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    int   d;
    int   c;
    int   cyc;
    logic rise;
    logic ep;
    logic flag;
  } exp_t;

  exp_t sb[$];

  input_conditioner_if #(.CH(4)) bus0 ();
  input_conditioner_if #(.CH(4)) bus1 ();

  input_conditioner #(.CH(4), .SYNC_STAGES(2), .DB_CYCLES(16), .RESET_LEVEL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  input_conditioner #(.CH(4), .SYNC_STAGES(3), .DB_CYCLES(1), .RESET_LEVEL(1'b0)) dut_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push(input int d, input int c, input int at, input logic rise,
                      input logic ep, input logic flag);
    exp_t x;
    x.d = d; x.c = c; x.cyc = at; x.rise = rise; x.ep = ep; x.flag = flag;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse seen on an output is matched against the scoreboard.
  always @(posedge clk) begin
    logic r, f, e, l, fl;
    int   idx;
    exp_t x;
    #2;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (d == 0) begin
          r = bus0.rise_out[c]; f = bus0.fall_out[c]; e = bus0.edge_pulse[c];
          l = bus0.level_out[c]; fl = bus0.event_flag[c];
        end else begin
          r = bus1.rise_out[c]; f = bus1.fall_out[c]; e = bus1.edge_pulse[c];
          l = bus1.level_out[c]; fl = bus1.event_flag[c];
        end
        if (r || f || e) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].d == d && sb[k].c == c) idx = k;
          if (idx < 0) begin
            check($sformatf("spurious_d%0d_c%0d", d, c), {29'd0, r, f, e}, 32'd0);
          end else begin
            x = sb[idx];
            sb.delete(idx);
            check($sformatf("cycle_d%0d_c%0d", d, c), cyc, x.cyc);
            check($sformatf("rise_d%0d_c%0d", d, c), {31'd0, r}, {31'd0, x.rise});
            check($sformatf("fall_d%0d_c%0d", d, c), {31'd0, f}, {31'd0, !x.rise});
            check($sformatf("pulse_d%0d_c%0d", d, c), {31'd0, e}, {31'd0, x.ep});
            check($sformatf("level_d%0d_c%0d", d, c), {31'd0, l}, {31'd0, x.rise});
            check($sformatf("flag_d%0d_c%0d", d, c), {31'd0, fl}, {31'd0, x.flag});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic v;
    bus0.async_in  = 4'b1000;
    bus0.edge_sel  = 8'b00_11_10_00;
    bus0.event_clr = '0;
    bus1.async_in  = '0;
    bus1.edge_sel  = 8'hFF;
    bus1.event_clr = '0;

    // Reset state with ch3 input already high.
    idle(3);
    check("rst_level0", {28'd0, bus0.level_out}, 32'd0);
    check("rst_pulses0", {20'd0, bus0.rise_out, bus0.fall_out, bus0.edge_pulse}, 32'd0);
    check("rst_flag0", {28'd0, bus0.event_flag}, 32'd0);
    check("rst_all1", {16'd0, bus1.level_out, bus1.rise_out, bus1.fall_out, bus1.event_flag}, 32'd0);
    rst_n = 1'b1;
    t = cyc;
    push(0, 3, t + 18, 1'b1, 1'b0, 1'b0);
    idle(25);

    // 10-cycle glitch on ch0 must never be accepted.
    bus0.async_in[0] = 1'b1;
    idle(10);
    bus0.async_in[0] = 1'b0;
    idle(30);
    check("glitch_level", {31'd0, bus0.level_out[0]}, 32'd0);
    check("glitch_flag", {31'd0, bus0.event_flag[0]}, 32'd0);

    // ch1 in fall-only mode: rise and fall pulse, edge_pulse/flag only on fall.
    bus0.async_in[1] = 1'b1;
    t = cyc;
    push(0, 1, t + 18, 1'b1, 1'b0, 1'b0);
    idle(30);
    bus0.async_in[1] = 1'b0;
    t = cyc;
    push(0, 1, t + 18, 1'b0, 1'b1, 1'b1);
    idle(30);
    check("ch1_flag_held", {31'd0, bus0.event_flag[1]}, 32'd1);

    // ch3 falls; mode none, so no edge_pulse or flag.
    bus0.async_in[3] = 1'b0;
    t = cyc;
    push(0, 3, t + 18, 1'b0, 1'b0, 1'b0);
    idle(25);

    // ch2 both-edge mode; clear coinciding with a new edge loses to the set.
    bus0.async_in[2] = 1'b1;
    t = cyc;
    push(0, 2, t + 18, 1'b1, 1'b1, 1'b1);
    idle(30);
    bus0.async_in[2] = 1'b0;
    t = cyc;
    push(0, 2, t + 18, 1'b0, 1'b1, 1'b1);
    idle(17);
    bus0.event_clr[2] = 1'b1;
    idle(1);
    check("set_wins", {31'd0, bus0.event_flag[2]}, 32'd1);
    idle(1);
    bus0.event_clr[2] = 1'b0;
    check("clr_alone", {31'd0, bus0.event_flag[2]}, 32'd0);
    idle(5);

    // Fast instance: staggered toggles, each channel follows at edge 4.
    for (int round = 0; round < 2; round++) begin
      for (int c = 0; c < 4; c++) begin
        v = !bus1.async_in[c];
        bus1.async_in[c] = v;
        push(1, c, cyc + 4, v, 1'b1, 1'b1);
        idle(1);
      end
      idle(10);
    end
    check("fast_level_back", {28'd0, bus1.level_out}, 32'd0);

    // Reset in the middle of a ch3 debounce count (cnt = 10).
    bus0.async_in[3] = 1'b1;
    idle(12);
    rst_n = 1'b0;
    #1;
    check("async_rst_flag0", {28'd0, bus0.event_flag}, 32'd0);
    check("async_rst_flag1", {28'd0, bus1.event_flag}, 32'd0);
    check("async_rst_level0", {28'd0, bus0.level_out}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    t = cyc;
    push(0, 3, t + 18, 1'b1, 1'b0, 1'b0);
    idle(17);
    check("midrst_not_yet", {31'd0, bus0.level_out[3]}, 32'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    idle(5);
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel input conditioner for push-buttons and external strobes feeding the LED display controller. Each channel synchronises an asynchronous input, debounces it, and produces a clean level, one-cycle rise/fall pulses, and a mode-selected sticky event flag with a clear handshake. It sits directly behind the board input pins and replaces the fixed single-channel rising-edge detector.

## Interface
- CH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DB_CYCLES, 16: consecutive cycles a new synchronised level must hold before it is accepted (≥1; 1 = no debounce).
- RESET_LEVEL, 1'b0: level loaded into the synchroniser and stable-level registers at reset.

One clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- async_in  in  CH  raw asynchronous inputs.
- edge_sel  in  2*CH  per-channel mode, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- event_clr  in  CH  per-channel clear of event_flag.
- level_out  out  CH  debounced level.
- rise_out  out  CH  one-cycle pulse on accepted 0→1.
- fall_out  out  CH  one-cycle pulse on accepted 1→0.
- edge_pulse  out  CH  rise_out/fall_out filtered by edge_sel.
- event_flag  out  CH  sticky copy of edge_pulse, held until cleared.

## Operation
- Per channel: SYNC_STAGES-deep shift register; last stage = sync level s.
- Debounce counter cnt, width $clog2(DB_CYCLES+1), and stable register q (= level_out).
- Each cycle: if s == q, cnt ← 0. If s != q and cnt == DB_CYCLES−1: q ← s, cnt ← 0, pulse rise_out (s=1) or fall_out (s=0). Else cnt ← cnt+1.
- Any return of s to q before acceptance clears cnt; glitches shorter than DB_CYCLES at s never reach level_out.
- edge_pulse[i] = (rise_out[i] & edge_sel[2i]) | (fall_out[i] & edge_sel[2i+1]), registered in the same cycle as rise/fall (no extra latency).
- event_flag[i]: set when the edge_pulse condition is true, cleared when event_clr[i]=1; simultaneous set and clear → set wins (flag stays 1).
- edge_sel is sampled every cycle; a change affects only edges accepted on or after that edge; it does not alter an already-set event_flag.
- Channels are fully independent; no arbitration.

## Timing
- Reset (asynchronous assertion, synchronous-release usage): sync chain and q = RESET_LEVEL, cnt = 0, rise_out/fall_out/edge_pulse/event_flag = 0. Because q and sync start equal, no edge is reported out of reset.
- Latency: input changed and held; counting the first capturing clock edge as edge 1, level_out and the rise/fall pulse update on edge SYNC_STAGES+DB_CYCLES (defaults: edge 18).
- rise_out/fall_out/edge_pulse high exactly one cycle per accepted transition; never both rise and fall in the same cycle.
- event_flag rises in the same cycle as edge_pulse; falls the cycle after event_clr sampled high (absent simultaneous set).
- Input toggling faster than DB_CYCLES: level_out frozen, no pulses.
- Reset mid-count: count discarded, outputs to reset values immediately.
- cnt never exceeds DB_CYCLES−1; no wrap.

## Structure
- Package input_conditioner_pkg: edge_sel encodings EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.
- Sub-module input_conditioner_ch (one channel: synchroniser, debounce counter, pulse and flag logic), instantiated CH times via generate; top level only slices buses.

## Test plan
- Reset with async_in=1, RESET_LEVEL=0, defaults: after release level_out rises on edge 18 with rise_out=1 for one cycle; no pulse during reset.
- Pulse of 10 cycles (< DB_CYCLES=16) on ch0: level_out, rise_out, event_flag stay 0.
- ch1 edge_sel=10, drive 0→1→0 each held 30 cycles: rise_out and fall_out each pulse once; edge_pulse and event_flag only on fall.
- ch2 edge_sel=11, event_flag set; assert event_clr in the same cycle as a new accepted edge: flag stays 1; clr alone next cycle → flag 0 following cycle.
- Assert rst_n low at cnt=10 during a transition: outputs return to reset values asynchronously; after release the transition needs a full 18 edges again.
- All four channels toggled with different offsets, DB_CYCLES=1, SYNC_STAGES=3: each channel's level_out follows its input at edge 4, independently.
